im_port_arbiter: RTL and testbench

Owns the single port of the synchronous-read instruction memory and shares it between the CPU fetch stage and the program loader that writes code words into it. After reset it sweeps the whole memory to zero, then grants one access per cycle: loader writes take priority, with a bounded streak so fetch is never starved. It translates fetch byte PCs (text base 0x3000) to word indices and flags fetches outside the memory window.

---
 rtl/im_pkg.sv | 13 +
 rtl/im_port_arbiter.sv | 123 ++++++++++++
 tb/tb_im_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/im_pkg.sv
// Shared defaults and state encoding for the instruction-memory port arbiter.
package im_pkg;

   localparam int unsigned DEPTH_LOG2_DEF   = 12;
   localparam logic [31:0] BASE_ADDR_DEF    = 32'h0000_3000;
   localparam int unsigned LD_BURST_MAX_DEF = 8;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/im_port_arbiter.sv
// Single-port instruction memory owner: zero-sweep after reset, then one access
// per cycle shared between loader writes (priority, bounded streak) and fetch reads.
module im_port_arbiter
   import im_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2     = DEPTH_LOG2_DEF,
   parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
   parameter int unsigned LD_BURST_MAX   = LD_BURST_MAX_DEF,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_req,
   input  logic [31:0]           fetch_pc,
   output logic                  fetch_gnt,
   output logic                  fetch_rvalid,
   output logic [31:0]           fetch_instr,
   output logic                  fetch_fault,
   input  logic                  ld_req,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_wdata,
   output logic                  ld_gnt,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  clear_done
);

   localparam int unsigned STREAK_W = $clog2(LD_BURST_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LD_BURST_MAX);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_sweep;
   logic [DEPTH_LOG2-1:0] w_sweep_nxt;
   logic [STREAK_W-1:0]   r_streak;
   logic [STREAK_W-1:0]   w_streak_nxt;
   logic                  r_clear_done;
   logic                  r_rvalid;
   logic                  r_fault;
   logic [31:0]           r_hold;

   logic [31:0]           w_off;
   logic                  w_fault;
   logic [DEPTH_LOG2-1:0] w_index;

   // Byte PC to word index; anything misaligned or beyond the window faults.
   assign w_off   = fetch_pc - BASE_ADDR;
   assign w_fault = (w_off[1:0] != 2'b00) || (w_off[31:DEPTH_LOG2+2] != '0);
   assign w_index = w_off[DEPTH_LOG2+1:2];

   always_comb begin
      w_state_nxt  = r_state;
      w_sweep_nxt  = r_sweep;
      w_streak_nxt = r_streak;
      fetch_gnt    = 1'b0;
      ld_gnt       = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      // Port stays quiet while reset is held.
      if (rst_n) begin
         case (r_state)
            CLEAR: begin
               mem_en      = 1'b1;
               mem_we      = 1'b1;
               mem_addr    = r_sweep;
               w_sweep_nxt = DEPTH_LOG2'(r_sweep + 1'b1);
               if (r_sweep == '1) w_state_nxt = RUN;
            end
            RUN: begin
               if (ld_req && !(fetch_req && (r_streak == STREAK_MAX))) begin
                  ld_gnt    = 1'b1;
                  mem_en    = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = ld_addr;
                  mem_wdata = ld_wdata;
                  if (!fetch_req)                w_streak_nxt = '0;
                  else if (r_streak != STREAK_MAX) w_streak_nxt = STREAK_W'(r_streak + 1'b1);
               end else begin
                  w_streak_nxt = '0;
                  if (fetch_req) begin
                     fetch_gnt = 1'b1;
                     mem_en    = !w_fault;
                     mem_addr  = w_index;
                  end
               end
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= CLEAR_ON_RESET ? CLEAR : RUN;
         r_sweep      <= '0;
         r_streak     <= '0;
         r_clear_done <= 1'b0;
         r_rvalid     <= 1'b0;
         r_fault      <= 1'b0;
         r_hold       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_sweep      <= w_sweep_nxt;
         r_streak     <= w_streak_nxt;
         r_clear_done <= (w_state_nxt == RUN);
         r_rvalid     <= fetch_gnt;
         r_fault      <= fetch_gnt & w_fault;
         if (r_rvalid) r_hold <= fetch_instr;
      end
   end

   // Read data arrives from the memory one cycle after the strobe; only the select is registered.
   assign fetch_rvalid = r_rvalid;
   assign fetch_fault  = r_fault;
   assign fetch_instr  = r_rvalid ? (r_fault ? 32'h0 : mem_rdata) : r_hold;
   assign clear_done   = r_clear_done;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Self-checking bench for im_port_arbiter: directed table, loader-streak pattern,
// randomized traffic against an array-based reference model, mid-run reset.
module tb_im_port_arbiter;
   import im_pkg::*;

   localparam int unsigned DL    = 12;
   localparam int unsigned DEPTH = 4096;
   localparam int          BURST = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_req;
   logic [31:0]   fetch_pc;
   logic          fetch_gnt;
   logic          fetch_rvalid;
   logic [31:0]   fetch_instr;
   logic          fetch_fault;
   logic          ld_req;
   logic [DL-1:0] ld_addr;
   logic [31:0]   ld_wdata;
   logic          ld_gnt;
   logic          mem_en;
   logic          mem_we;
   logic [DL-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = 32'h0;
   logic          clear_done;

   im_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .clear_done(clear_done)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory; scrambled during reset so the sweep has something to erase.
   logic [31:0] bmem [DEPTH];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) bmem[i] <= 32'hA5A5_0000 ^ 32'(i);
      end else if (mem_en) begin
         if (mem_we) bmem[mem_addr] <= mem_wdata;
         else        mem_rdata      <= bmem[mem_addr];
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory contents as an array, grant policy from the rules.
   int          m_streak;
   bit          m_pend;
   bit          m_pend_flt;
   logic [31:0] m_pend_ins;
   logic [31:0] m_last;
   logic [31:0] ref_mem [DEPTH];

   task automatic model_reset();
      m_streak = 0;
      m_pend   = 1'b0;
      m_last   = 32'h0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
   endtask

   // One RUN cycle: drive, check against the model, advance the model, move to next negedge.
   task automatic cycle(input bit fq, input logic [31:0] pc, input bit lq,
                        input logic [DL-1:0] la, input logic [31:0] lw,
                        output bit o_fg, output bit o_lg, output bit o_rv,
                        output bit o_fl, output logic [31:0] o_in);
      logic [31:0] off;
      bit          flt, lwin, fwin;
      int          idx;
      fetch_req = fq; fetch_pc = pc; ld_req = lq; ld_addr = la; ld_wdata = lw;
      #1;
      off  = pc - 32'h0000_3000;
      flt  = (off % 4 != 0) || (off >= 4 * DEPTH);
      idx  = flt ? 0 : int'(off / 4);
      lwin = lq && !(fq && m_streak == BURST);
      fwin = fq && !lwin;
      chk("fetch_gnt", 32'(fetch_gnt), 32'(fwin));
      chk("ld_gnt",    32'(ld_gnt),    32'(lwin));
      chk("mem_en",    32'(mem_en),    32'(lwin || (fwin && !flt)));
      if (lwin) begin
         chk("mem_we_wr",  32'(mem_we),   32'h1);
         chk("mem_addr_wr", 32'(mem_addr), 32'(la));
         chk("mem_wdata",  mem_wdata,     lw);
      end else if (fwin && !flt) begin
         chk("mem_we_rd",  32'(mem_we),   32'h0);
         chk("mem_addr_rd", 32'(mem_addr), 32'(idx));
      end
      chk("fetch_rvalid", 32'(fetch_rvalid), 32'(m_pend));
      if (m_pend) begin
         chk("fetch_fault", 32'(fetch_fault), 32'(m_pend_flt));
         m_last = m_pend_ins;
      end
      chk("fetch_instr", fetch_instr, m_last);
      o_fg = fetch_gnt; o_lg = ld_gnt; o_rv = fetch_rvalid; o_fl = fetch_fault; o_in = fetch_instr;
      m_pend     = fwin;
      m_pend_flt = flt;
      m_pend_ins = flt ? 32'h0 : ref_mem[idx];
      if (lwin) ref_mem[la] = lw;
      if (lwin && fq) m_streak = (m_streak < BURST) ? m_streak + 1 : BURST;
      else            m_streak = 0;
      @(negedge clk);
   endtask

   // Entered just after the negedge on which rst_n was released.
   task automatic sweep_check();
      int errs = 0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         #1;
         if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== DL'(k) || mem_wdata !== 32'h0 ||
             fetch_gnt !== 1'b0 || ld_gnt !== 1'b0 || clear_done !== 1'b0) begin
            if (errs < 4) $display("sweep k=%0d en=%b we=%b addr=%0d fg=%b lg=%b cd=%b",
                                   k, mem_en, mem_we, mem_addr, fetch_gnt, ld_gnt, clear_done);
            errs++;
         end
         @(negedge clk);
      end
      chk("sweep_errors", 32'(errs), 32'h0);
      chk("clear_done_rise", 32'(clear_done), 32'h1);
   endtask

   typedef struct {
      bit          fq;
      logic [31:0] pc;
      bit          lq;
      logic [DL-1:0] la;
      logic [31:0] lw;
      bit          e_fg;
      bit          e_lg;
      bit          e_rv;
      bit          e_fl;
      logic [31:0] e_in;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got time %0t expected < 1000000", $time);
      $fatal(1);
   end

   initial begin
      bit fg, lg, rv, fl;
      logic [31:0] ins;
      int fcnt;

      //                 fq  pc            lq la   lw             fg lg rv fl instr(next)
      tbl[0]  = '{1'b0, 32'h0,       1'b1, 12'd0, 32'h2402000A, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0,       1'b1, 12'd1, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 32'h3000,    1'b0, 12'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h2402000A};
      tbl[3]  = '{1'b1, 32'h3004,    1'b0, 12'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h11111111};
      tbl[4]  = '{1'b1, 32'h3008,    1'b0, 12'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 32'h2FFC,    1'b0, 12'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
      tbl[6]  = '{1'b1, 32'h7000,    1'b0, 12'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
      tbl[7]  = '{1'b1, 32'h3002,    1'b0, 12'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
      tbl[8]  = '{1'b1, 32'h3004,    1'b0, 12'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h11111111};
      tbl[9]  = '{1'b0, 32'h0,       1'b0, 12'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h11111111};
      tbl[10] = '{1'b0, 32'h0,       1'b0, 12'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h11111111};

      rst_n = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h3000; ld_req = 1'b1; ld_addr = '0; ld_wdata = 32'hFFFF_FFFF;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_fetch_gnt",    32'(fetch_gnt),    32'h0);
      chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'h0);
      chk("rst_fetch_instr",  fetch_instr,       32'h0);
      chk("rst_fetch_fault",  32'(fetch_fault),  32'h0);
      chk("rst_ld_gnt",       32'(ld_gnt),       32'h0);
      chk("rst_mem_en",       32'(mem_en),       32'h0);
      chk("rst_mem_we",       32'(mem_we),       32'h0);
      chk("rst_mem_addr",     32'(mem_addr),     32'h0);
      chk("rst_mem_wdata",    mem_wdata,         32'h0);
      chk("rst_clear_done",   32'(clear_done),   32'h0);
      @(negedge clk);
      rst_n = 1'b1; ld_req = 1'b0;
      sweep_check();

      // Fetch held through the sweep is granted in the cycle clear_done rises.
      cycle(1'b1, 32'h3000, 1'b0, '0, '0, fg, lg, rv, fl, ins);
      chk("first_gnt_at_clear_done", 32'(fg), 32'h1);
      cycle(1'b0, 32'h0, 1'b0, '0, '0, fg, lg, rv, fl, ins);
      chk("swept_word_zero", ins, 32'h0);

      for (int i = 0; i < NV; i++) begin
         cycle(tbl[i].fq, tbl[i].pc, tbl[i].lq, tbl[i].la, tbl[i].lw, fg, lg, rv, fl, ins);
         chk("tbl_fetch_gnt", 32'(fg), 32'(tbl[i].e_fg));
         chk("tbl_ld_gnt",    32'(lg), 32'(tbl[i].e_lg));
         if (i > 0) begin
            chk("tbl_rvalid", 32'(rv), 32'(tbl[i-1].e_rv));
            if (tbl[i-1].e_rv) chk("tbl_fault", 32'(fl), 32'(tbl[i-1].e_fl));
            chk("tbl_instr", ins, tbl[i-1].e_in);
         end
      end

      // Both requesters held: 8 loader grants then 1 fetch grant, repeating.
      fcnt = 0;
      for (int j = 0; j < 27; j++) begin
         cycle(1'b1, 32'h3000 + 32'($urandom_range(0, 15)) * 4, 1'b1,
               DL'($urandom_range(0, 15)), $urandom, fg, lg, rv, fl, ins);
         chk("burst_pattern", 32'(fg), 32'((j % 9) == 8));
         if (fg) fcnt++;
      end
      chk("burst_fetch_count", 32'(fcnt), 32'h3);
      cycle(1'b0, 32'h0, 1'b0, '0, '0, fg, lg, rv, fl, ins);

      for (int j = 0; j < 3000; j++) begin
         logic [31:0] pc;
         int r = int'($urandom_range(0, 9));
         if (r < 5)      pc = 32'h3000 + 32'($urandom_range(0, 15)) * 4;
         else if (r < 8) pc = 32'h3000 + 32'($urandom_range(0, DEPTH - 1)) * 4;
         else            pc = $urandom;
         cycle($urandom_range(0, 9) < 7, pc, $urandom_range(0, 1) == 1,
               DL'($urandom_range(0, 15)), $urandom, fg, lg, rv, fl, ins);
      end

      // Reset while a fetch response is pending.
      fetch_req = 1'b1; fetch_pc = 32'h3004; ld_req = 1'b0;
      #1;
      chk("pre_reset_gnt", 32'(fetch_gnt), 32'h1);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_drops_rvalid", 32'(fetch_rvalid), 32'h0);
      chk("reset_clear_done",   32'(clear_done),   32'h0);
      chk("reset_instr",        fetch_instr,       32'h0);
      rst_n = 1'b1;
      model_reset();
      sweep_check();
      cycle(1'b1, 32'h3000, 1'b0, '0, '0, fg, lg, rv, fl, ins);
      cycle(1'b0, 32'h0, 1'b0, '0, '0, fg, lg, rv, fl, ins);
      chk("post_reset_swept", ins, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
